// File: rtl/slink_alloc_ctrl_pkg.sv
// Shared types and helpers for the channel-allocator reconfiguration controller.
package slink_alloc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    CLEAR = 2'd2,
    APPLY = 2'd3
  } state_e;

  // Widest mask the popcount helper accepts; callers zero-extend into it.
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] vec,
                                           input int unsigned         width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width && vec[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/slink_channel_alloc_ctrl.sv
// Sequences halt/drain/clear/apply for a channel-mask change on the spread/despread datapath.
// Optional perf counters are compiled in with `define SLINK_ALLOC_CTRL_PERF_EN.
module slink_channel_alloc_ctrl
  import slink_alloc_ctrl_pkg::*;
#(
  parameter int unsigned NumChannels  = 8,
  parameter int unsigned DrainTimeout = 256,
  parameter int unsigned CntWidth     = $clog2(DrainTimeout)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_req_i,
  input  logic [NumChannels-1:0]         cfg_mask_i,
  output logic                           cfg_ack_o,
  output logic                           cfg_err_o,
  input  logic                           dp_busy_i,
  output logic                           dp_halt_o,
  output logic                           dp_clear_o,
  output logic [NumChannels-1:0]         active_mask_o,
  output logic [$clog2(NumChannels):0]   num_active_o,
  output logic                           drain_timeout_o
`ifdef SLINK_ALLOC_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_reconf_cnt_o,
  output logic [15:0]                    perf_timeout_cnt_o
`endif
);

  localparam int unsigned PopWidth = $clog2(NumChannels) + 1;

  state_e                 state;
  logic [NumChannels-1:0] pending_mask;
  logic [CntWidth-1:0]    drain_cnt;
  logic                   run_req;
  logic                   req_zero;
  logic                   req_same;
  logic                   forced_clear;

  // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    run_req      = (state == RUN) && cfg_req_i;
    req_zero     = (cfg_mask_i == '0);
    req_same     = (cfg_mask_i == active_mask_o);
    forced_clear = (state == HALT) && dp_busy_i &&
                   (drain_cnt == CntWidth'(DrainTimeout - 1));
  end

  // Zero and no-change requests are answered in the same RUN cycle; all else is decoded from state.
  assign cfg_ack_o  = (state == APPLY) || (run_req && (req_zero || req_same));
  assign cfg_err_o  = run_req && req_zero;
  assign dp_halt_o  = (state != RUN);
  assign dp_clear_o = (state == CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= RUN;
      pending_mask    <= '0;
      drain_cnt       <= '0;
      active_mask_o   <= '1;
      num_active_o    <= PopWidth'(NumChannels);
      drain_timeout_o <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (run_req && !req_zero && !req_same) begin
            pending_mask    <= cfg_mask_i;
            drain_cnt       <= '0;
            drain_timeout_o <= 1'b0;
            state           <= HALT;
          end
        end
        HALT: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (!dp_busy_i) begin
            state <= CLEAR;
          end else if (forced_clear) begin
            drain_timeout_o <= 1'b1;
            state           <= CLEAR;
          end
        end
        CLEAR: begin
          active_mask_o <= pending_mask;
          num_active_o  <= PopWidth'(popcount(MaxWidth'(pending_mask), NumChannels));
          state         <= APPLY;
        end
        APPLY: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef SLINK_ALLOC_CTRL_PERF_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_reconf_cnt_o  <= '0;
      perf_timeout_cnt_o <= '0;
    end else begin
      if (state == APPLY && perf_reconf_cnt_o != '1)
        perf_reconf_cnt_o <= perf_reconf_cnt_o + 1'b1;
      if (forced_clear && perf_timeout_cnt_o != '1)
        perf_timeout_cnt_o <= perf_timeout_cnt_o + 1'b1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_slink_channel_alloc_ctrl.sv
// Self-checking bench for slink_channel_alloc_ctrl: vector table plus multi-cycle drain/timeout/reset sequences.
module tb_slink_channel_alloc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_req_i;
  logic [7:0] cfg_mask_i;
  logic       cfg_ack_o;
  logic       cfg_err_o;
  logic       dp_busy_i;
  logic       dp_halt_o;
  logic       dp_clear_o;
  logic [7:0] active_mask_o;
  logic [3:0] num_active_o;
  logic       drain_timeout_o;
`ifdef SLINK_ALLOC_CTRL_PERF_EN
  logic [31:0] perf_reconf_cnt_o;
  logic [15:0] perf_timeout_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  slink_channel_alloc_ctrl #(
    .NumChannels (8),
    .DrainTimeout(16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_req_i      (cfg_req_i),
    .cfg_mask_i     (cfg_mask_i),
    .cfg_ack_o      (cfg_ack_o),
    .cfg_err_o      (cfg_err_o),
    .dp_busy_i      (dp_busy_i),
    .dp_halt_o      (dp_halt_o),
    .dp_clear_o     (dp_clear_o),
    .active_mask_o  (active_mask_o),
    .num_active_o   (num_active_o),
    .drain_timeout_o(drain_timeout_o)
`ifdef SLINK_ALLOC_CTRL_PERF_EN
    ,
    .perf_reconf_cnt_o (perf_reconf_cnt_o),
    .perf_timeout_cnt_o(perf_timeout_cnt_o)
`endif
  );

  typedef struct {
    logic       req;
    logic [7:0] mask;
    logic       busy;
    logic       ack;
    logic       err;
    logic       halt;
    logic       clr;
    logic [7:0] act;
    logic [3:0] num;
    logic       to;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one reconfiguration from an idle RUN cycle; busy is high on HALT cycles 1..busy_cycles.
  task automatic run_reconf(input logic [7:0] m, input int busy_cycles,
                            output int clr_c, output int ack_c);
    cfg_req_i  = 1'b1;
    cfg_mask_i = m;
    dp_busy_i  = 1'b0;
    tick();
    cfg_req_i  = 1'b0;
    clr_c = -1;
    ack_c = -1;
    for (int c = 1; c <= 60; c++) begin
      dp_busy_i = (c <= busy_cycles);
      @(negedge clk_i);
      if (dp_clear_o) clr_c = c;
      if (cfg_ack_o)  ack_c = c;
      tick();
      if (ack_c >= 0) break;
    end
    dp_busy_i = 1'b0;
  endtask

  initial begin
    int clr_c, ack_c;
    logic seen_ack;

    //             req   mask   busy  ack   err   halt  clr   act    num   to
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0}; // idle after reset
    tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0}; // zero mask rejected
    tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0}; // same mask fast ack
    tbl[3] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0}; // accept
    tbl[4] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd8, 1'b0}; // HALT, mask change ignored
    tbl[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd8, 1'b0}; // CLEAR
    tbl[6] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F, 4'd4, 1'b0}; // APPLY
    tbl[7] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b0}; // back in RUN

    rst_i      = 1'b1;
    cfg_req_i  = 1'b0;
    cfg_mask_i = '0;
    dp_busy_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cfg_req_i  = tbl[i].req;
      cfg_mask_i = tbl[i].mask;
      dp_busy_i  = tbl[i].busy;
      @(negedge clk_i);
      check($sformatf("v%0d_ack", i),  32'(cfg_ack_o),       32'(tbl[i].ack));
      check($sformatf("v%0d_err", i),  32'(cfg_err_o),       32'(tbl[i].err));
      check($sformatf("v%0d_halt", i), 32'(dp_halt_o),       32'(tbl[i].halt));
      check($sformatf("v%0d_clr", i),  32'(dp_clear_o),      32'(tbl[i].clr));
      check($sformatf("v%0d_mask", i), 32'(active_mask_o),   32'(tbl[i].act));
      check($sformatf("v%0d_num", i),  32'(num_active_o),    32'(tbl[i].num));
      check($sformatf("v%0d_to", i),   32'(drain_timeout_o), 32'(tbl[i].to));
      tick();
    end

    // Busy drain of 10 cycles: clear in cycle 12, ack in cycle 13.
    run_reconf(8'h81, 10, clr_c, ack_c);
    check("busy_clr_cycle", 32'(clr_c), 32'd12);
    check("busy_ack_cycle", 32'(ack_c), 32'd13);
    check("busy_mask", 32'(active_mask_o), 32'h81);
    check("busy_num", 32'(num_active_o), 32'd2);
    check("busy_to", 32'(drain_timeout_o), 32'd0);
    check("busy_halt_dropped", 32'(dp_halt_o), 32'd0);

    // Stuck busy: forced clear after 16 HALT cycles.
    run_reconf(8'h3C, 1000, clr_c, ack_c);
    check("to_clr_cycle", 32'(clr_c), 32'd17);
    check("to_ack_cycle", 32'(ack_c), 32'd18);
    check("to_mask", 32'(active_mask_o), 32'h3C);
    check("to_num", 32'(num_active_o), 32'd4);
    check("to_sticky", 32'(drain_timeout_o), 32'd1);

    // A fast-path ack does not count as an accepted request; the flag stays.
    cfg_req_i  = 1'b1;
    cfg_mask_i = 8'h3C;
    @(negedge clk_i);
    check("to_fast_ack", 32'(cfg_ack_o), 32'd1);
    check("to_fast_err", 32'(cfg_err_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    @(negedge clk_i);
    check("to_sticky_after_fast", 32'(drain_timeout_o), 32'd1);
    tick();

    // Next accepted request clears the flag; idle datapath gives 3-cycle latency.
    run_reconf(8'hF0, 0, clr_c, ack_c);
    check("f0_clr_cycle", 32'(clr_c), 32'd2);
    check("f0_ack_cycle", 32'(ack_c), 32'd3);
    check("f0_to_cleared", 32'(drain_timeout_o), 32'd0);
    check("f0_num", 32'(num_active_o), 32'd4);
`ifdef SLINK_ALLOC_CTRL_PERF_EN
    check("perf_reconf", perf_reconf_cnt_o, 32'd4);
    check("perf_timeout", 32'(perf_timeout_cnt_o), 32'd1);
`endif

    // Reset while in HALT aborts without ack.
    cfg_req_i  = 1'b1;
    cfg_mask_i = 8'h01;
    tick();
    cfg_req_i = 1'b0;
    dp_busy_i = 1'b1;
    rst_i     = 1'b1;
    @(negedge clk_i);
    check("rst_in_halt", 32'(dp_halt_o), 32'd1);
    tick();
    rst_i     = 1'b0;
    dp_busy_i = 1'b0;
    @(negedge clk_i);
    check("rst_halt_dropped", 32'(dp_halt_o), 32'd0);
    check("rst_mask", 32'(active_mask_o), 32'hFF);
    check("rst_num", 32'(num_active_o), 32'd8);
`ifdef SLINK_ALLOC_CTRL_PERF_EN
    check("rst_perf_reconf", perf_reconf_cnt_o, 32'd0);
    check("rst_perf_timeout", 32'(perf_timeout_cnt_o), 32'd0);
`endif
    seen_ack = cfg_ack_o | dp_clear_o;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk_i);
      seen_ack = seen_ack | cfg_ack_o | dp_clear_o;
    end
    check("rst_no_ack", 32'(seen_ack), 32'd0);
    check("rst_mask_kept", 32'(active_mask_o), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slink_channel_alloc_ctrl.md
Name: slink_channel_alloc_ctrl

Overview:
Controller that sequences channel-mask reconfiguration for the channel allocator's spread/despread datapath. It accepts a new active-channel mask from the config register file and halts upstream traffic. It waits for the despread datapath to drain, pulses its clear, then applies the new mask and reports completion. It sits between the register file and the channel allocator spread/despread stages.

Parameters:
NumChannels, 8, number of physical channels (width of all masks); must be >= 2.
DrainTimeout, 256, max cycles spent in HALT before a forced clear; must be >= 2.
CntWidth, $clog2(DrainTimeout), drain counter width (derived).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cfg_req_i  in  1  reconfiguration request; held high until cfg_ack_o
cfg_mask_i  in  NumChannels  requested active-channel mask; sampled when the request is accepted
cfg_ack_o  out  1  one-cycle completion/response pulse
cfg_err_o  out  1  valid with cfg_ack_o; 1 = request rejected (zero mask)
dp_busy_i  in  1  datapath holds in-flight data (despreader not idle)
dp_halt_o  out  1  stop upstream from issuing new words into the datapath
dp_clear_o  out  1  one-cycle clear to the spread/despread stages
active_mask_o  out  NumChannels  currently applied channel mask
num_active_o  out  $clog2(NumChannels)+1  popcount of active_mask_o
drain_timeout_o  out  1  sticky: last drain ended by timeout

Behaviour:
- One clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - state RUN
  - active_mask_o all ones; num_active_o = NumChannels
  - dp_halt_o = 0, dp_clear_o = 0, cfg_ack_o = 0, cfg_err_o = 0, drain_timeout_o = 0
  - drain counter 0
- Reset mid-operation aborts any reconfiguration without an ack. The pending mask is discarded.
- States RUN, HALT, CLEAR, APPLY. All outputs are registered or decoded from state only, except the RUN fast-path ack.
- RUN, with cfg_req_i low: no action.
- RUN, with cfg_req_i high:
  - cfg_mask_i == 0: cfg_ack_o = 1 and cfg_err_o = 1 combinationally in the same cycle. Stay in RUN; mask unchanged.
  - cfg_mask_i == active mask: cfg_ack_o = 1, cfg_err_o = 0 in the same cycle. No drain, no clear.
  - otherwise: latch cfg_mask_i into the pending register, clear the counter and drain_timeout_o, then go to HALT.
- HALT:
  - dp_halt_o = 1; counter increments each cycle.
  - If dp_busy_i == 0, go to CLEAR.
  - Else if counter == DrainTimeout-1, set drain_timeout_o and go to CLEAR (forced).
  - Busy sampled low on the first HALT cycle exits after 1 cycle.
- CLEAR: dp_halt_o = 1, dp_clear_o = 1 for exactly one cycle. active_mask/num_active take the pending value at the end of this cycle. Go to APPLY.
- APPLY: dp_halt_o = 1, cfg_ack_o = 1, cfg_err_o = 0, with the new active_mask_o visible. Next state RUN, where dp_halt_o drops.
- Latency, accept to ack with an idle datapath: 3 cycles (HALT, CLEAR, APPLY). With busy for B cycles: B+3. Worst case: DrainTimeout+2.
- cfg_req_i/cfg_mask_i are ignored outside RUN. cfg_mask_i changes after acceptance have no effect.
- cfg_req_i still high in the RUN cycle after APPLY is treated as a new request. The requester must drop it on ack.
- num_active_o always equals popcount(active_mask_o). It is updated in the same cycle as the mask.

Optional Feature:
- Macro SLINK_ALLOC_CTRL_PERF_EN.
- Defined: adds outputs perf_reconf_cnt_o [31:0] and perf_timeout_cnt_o [15:0].
  - perf_reconf_cnt_o increments on each APPLY.
  - perf_timeout_cnt_o increments on each forced clear.
  - Both saturate at max, reset to 0, and are cleared by rst_i only.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package slink_alloc_ctrl_pkg holds:
  - the state_e enum (RUN, HALT, CLEAR, APPLY; 2-bit)
  - the popcount function parameterised by width
- No sub-module: popcount is a function and the FSM is small. The counter stays inline.

Test Plan:
- Reset, NumChannels=8 -> active_mask_o=8'hFF, num_active_o=8, all pulses 0; rst_i asserted in HALT -> RUN next cycle, mask 8'hFF, no ack.
- Req mask 8'h0F, dp_busy_i=0 -> dp_halt_o cycles 1-3, dp_clear_o cycle 2 only, ack cycle 3, active_mask_o=8'h0F, num_active_o=4, cfg_err_o=0.
- Req mask 8'h00 -> ack and err in the same cycle, no halt/clear, mask unchanged 8'hFF.
- Req mask equal to current (8'hFF) -> same-cycle ack, err=0, no halt/clear.
- Req 8'h81, dp_busy_i high for 10 cycles -> clear in cycle 12, ack in cycle 13, drain_timeout_o=0, num_active_o=2.
- DrainTimeout=16, dp_busy_i stuck high -> forced clear after 16 HALT cycles, ack next cycle, drain_timeout_o=1 until next accepted request; with SLINK_ALLOC_CTRL_PERF_EN, perf_timeout_cnt_o=1 and perf_reconf_cnt_o incremented.
